// File: rtl/student_dmux_stream.sv
// Registered N-way stream demultiplexer with per-channel one-entry holding registers.
// Routes each accepted word to one channel (explicit select or round-robin) or to all
// channels (broadcast). Broadcast loads all channels together or none of them.
module student_dmux_stream #(
    parameter int unsigned WIDTH    = 16,
    parameter int unsigned SEL_BITS = 3
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [WIDTH-1:0]                  in_data,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [SEL_BITS-1:0]               sel,
    input  logic [1:0]                        mode,
    output logic [(2**SEL_BITS)*WIDTH-1:0]    out_data,
    output logic [2**SEL_BITS-1:0]            out_valid,
    input  logic [2**SEL_BITS-1:0]            out_ready,
    output logic [SEL_BITS-1:0]               rr_ptr
);

    localparam int unsigned NUM_OUT = 2 ** SEL_BITS;

    typedef enum logic [1:0] {
        ModeExplicit  = 2'b00,
        ModeRound     = 2'b01,
        ModeBroadcast = 2'b10,
        ModeAlias     = 2'b11
    } mode_e;

    logic [WIDTH-1:0]    data_q [NUM_OUT];
    logic [WIDTH-1:0]    data_d [NUM_OUT];
    logic [NUM_OUT-1:0]  valid_q, valid_d;
    logic [SEL_BITS-1:0] rr_ptr_q, rr_ptr_d;

    logic [NUM_OUT-1:0]  sel_onehot;
    logic [NUM_OUT-1:0]  rr_onehot;
    logic [NUM_OUT-1:0]  target;
    logic [NUM_OUT-1:0]  free;
    logic [NUM_OUT-1:0]  load;
    logic                accept;

    // Comparator-based one-hot decode of the explicit select and the round-robin pointer.
    always_comb begin
        sel_onehot = '0;
        rr_onehot  = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            sel_onehot[k] = (sel == SEL_BITS'(k));
            rr_onehot[k]  = (rr_ptr_q == SEL_BITS'(k));
        end
    end

    // Target set, readiness and the per-channel load strobe.
    always_comb begin
        unique case (mode_e'(mode))
            ModeRound:     target = rr_onehot;
            ModeBroadcast: target = '1;
            ModeExplicit,
            ModeAlias:     target = sel_onehot;
            default:       target = sel_onehot;
        endcase
        // A channel is free when empty or being drained this cycle.
        free     = ~valid_q | out_ready;
        // Every targeted channel must be free; untargeted channels never block.
        in_ready = &(free | ~target);
        accept   = in_valid & in_ready;
        load     = target & {NUM_OUT{accept}};
    end

    // Next state: load wins over drain, so a same-cycle drain+load keeps the channel valid.
    always_comb begin
        valid_d  = valid_q;
        rr_ptr_d = rr_ptr_q;
        for (int k = 0; k < NUM_OUT; k++) begin
            data_d[k] = data_q[k];
            if (load[k]) begin
                data_d[k]  = in_data;
                valid_d[k] = 1'b1;
            end else if (out_ready[k]) begin
                valid_d[k] = 1'b0;
            end
        end
        if (accept && (mode == ModeRound)) begin
            rr_ptr_d = rr_ptr_q + SEL_BITS'(1);
        end
    end

    // State registers, cleared immediately by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q  <= '0;
            rr_ptr_q <= '0;
            for (int k = 0; k < NUM_OUT; k++) begin
                data_q[k] <= '0;
            end
        end else begin
            valid_q  <= valid_d;
            rr_ptr_q <= rr_ptr_d;
            for (int k = 0; k < NUM_OUT; k++) begin
                data_q[k] <= data_d[k];
            end
        end
    end

    // Flatten the holding registers onto the output bus.
    always_comb begin
        out_data = '0;
        for (int k = 0; k < NUM_OUT; k++) begin
            out_data[k*WIDTH +: WIDTH] = data_q[k];
        end
        out_valid = valid_q;
        rr_ptr    = rr_ptr_q;
    end

endmodule

// File: tb/tb_student_dmux_stream.sv
// Directed self-checking bench for student_dmux_stream (WIDTH=16, SEL_BITS=3).
module tb_student_dmux_stream;

    localparam int unsigned WIDTH    = 16;
    localparam int unsigned SEL_BITS = 3;
    localparam int unsigned NUM_OUT  = 8;

    logic                     clk;
    logic                     reset;
    logic [WIDTH-1:0]         in_data;
    logic                     in_valid;
    logic                     in_ready;
    logic [SEL_BITS-1:0]      sel;
    logic [1:0]               mode;
    logic [NUM_OUT*WIDTH-1:0] out_data;
    logic [NUM_OUT-1:0]       out_valid;
    logic [NUM_OUT-1:0]       out_ready;
    logic [SEL_BITS-1:0]      rr_ptr;

    int vectors;
    int miscompares;

    student_dmux_stream #(
        .WIDTH    (WIDTH),
        .SEL_BITS (SEL_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .mode      (mode),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rr_ptr    (rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        sel       = '0;
        mode      = 2'b00;
        out_ready = '0;
        tick();
        tick();
        vectors++;
        if (out_valid !== 8'h00) begin
            $display("FAIL reset_valid: got %h want %h", out_valid, 8'h00);
            miscompares++;
        end
        vectors++;
        if (out_data !== '0) begin
            $display("FAIL reset_data: got %h want 0", out_data);
            miscompares++;
        end
        vectors++;
        if (rr_ptr !== 3'd0) begin
            $display("FAIL reset_rr: got %0d want 0", rr_ptr);
            miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL reset_in_ready: got %b want 1", in_ready);
            miscompares++;
        end
        reset = 1'b0;
        #1;
    endtask

    task automatic test_explicit();
        logic [NUM_OUT*WIDTH-1:0] exp_data;
        exp_data = '0;
        exp_data[5*WIDTH +: WIDTH] = 16'hA5A5;
        mode = 2'b00; sel = 3'd5; in_data = 16'hA5A5; in_valid = 1'b1; out_ready = '0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL expl_ready_before: got %b want 1", in_ready);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 8'b0010_0000) begin
            $display("FAIL expl_valid: got %b want 00100000", out_valid);
            miscompares++;
        end
        vectors++;
        if (out_data !== exp_data) begin
            $display("FAIL expl_data: got %h want %h", out_data, exp_data);
            miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL expl_ready_full: got %b want 0", in_ready);
            miscompares++;
        end
    endtask

    task automatic test_backpressure();
        sel = 3'd5; in_data = 16'h1234; in_valid = 1'b1; out_ready = '0;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bp_stall_ready: got %b want 0", in_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_data[5*WIDTH +: WIDTH] !== 16'hA5A5 || out_valid !== 8'h20) begin
            $display("FAIL bp_hold: got %h/%h want a5a5/20",
                     out_data[5*WIDTH +: WIDTH], out_valid);
            miscompares++;
        end
        out_ready = 8'h20;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bp_release_ready: got %b want 1", in_ready);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_data[5*WIDTH +: WIDTH] !== 16'h1234 || out_valid !== 8'h20) begin
            $display("FAIL bp_reload: got %h/%h want 1234/20",
                     out_data[5*WIDTH +: WIDTH], out_valid);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_valid !== 8'h00) begin
            $display("FAIL bp_drain: got %h want 00", out_valid);
            miscompares++;
        end
    endtask

    task automatic test_round_robin();
        mode = 2'b01; out_ready = 8'hFF;
        for (int i = 0; i < 10; i++) begin
            in_data  = WIDTH'(i);
            sel      = SEL_BITS'(i) ^ 3'd3;
            in_valid = 1'b1;
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                $display("FAIL rr_ready[%0d]: got %b want 1", i, in_ready);
                miscompares++;
            end
            tick();
            vectors++;
            if (out_valid !== (8'h01 << (i % 8)) ||
                out_data[(i % 8)*WIDTH +: WIDTH] !== WIDTH'(i)) begin
                $display("FAIL rr_word[%0d]: got %h/%h want %h/%h", i, out_valid,
                         out_data[(i % 8)*WIDTH +: WIDTH], 8'h01 << (i % 8), i);
                miscompares++;
            end
        end
        in_valid = 1'b0;
        #1;
        vectors++;
        if (rr_ptr !== 3'd2) begin
            $display("FAIL rr_ptr_end: got %0d want 2", rr_ptr);
            miscompares++;
        end
        tick();
    endtask

    task automatic test_broadcast();
        mode = 2'b00; sel = 3'd3; in_data = 16'h0333; in_valid = 1'b1; out_ready = '0;
        tick();
        mode = 2'b10; sel = 3'd0; in_data = 16'hBEEF; out_ready = 8'hF7;
        #1;
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("FAIL bc_blocked_ready: got %b want 0", in_ready);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_valid !== 8'h08 || out_data[3*WIDTH +: WIDTH] !== 16'h0333 ||
            out_data[0 +: WIDTH] !== 16'd8) begin
            $display("FAIL bc_no_partial: got %h/%h/%h want 08/0333/0008", out_valid,
                     out_data[3*WIDTH +: WIDTH], out_data[0 +: WIDTH]);
            miscompares++;
        end
        out_ready = 8'hFF;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("FAIL bc_release_ready: got %b want 1", in_ready);
            miscompares++;
        end
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 8'hFF || out_data !== {8{16'hBEEF}}) begin
            $display("FAIL bc_all: got %h/%h want ff/all beef", out_valid, out_data);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_valid !== 8'h00 || rr_ptr !== 3'd2) begin
            $display("FAIL bc_after: got %h/%0d want 00/2", out_valid, rr_ptr);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        mode = 2'b00; sel = 3'd2; in_data = 16'h0222; in_valid = 1'b1; out_ready = '0;
        tick();
        out_ready = 8'hFB; sel = 3'd6;
        for (int i = 1; i <= 3; i++) begin
            in_data = 16'h6000 + WIDTH'(i);
            #1;
            vectors++;
            if (in_ready !== 1'b1) begin
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, in_ready);
                miscompares++;
            end
            tick();
            vectors++;
            if (out_valid !== 8'h44 || out_data[6*WIDTH +: WIDTH] !== 16'h6000 + WIDTH'(i)) begin
                $display("FAIL b2b_word[%0d]: got %h/%h want 44/%h", i, out_valid,
                         out_data[6*WIDTH +: WIDTH], 16'h6000 + WIDTH'(i));
                miscompares++;
            end
        end
        mode = 2'b01; in_data = 16'h7777;
        #1;
        vectors++;
        if (in_ready !== 1'b0 || rr_ptr !== 3'd2) begin
            $display("FAIL sw_blocked: got %b/%0d want 0/2", in_ready, rr_ptr);
            miscompares++;
        end
        tick();
        vectors++;
        if (out_valid !== 8'h04 || out_data[2*WIDTH +: WIDTH] !== 16'h0222) begin
            $display("FAIL sw_hold: got %h/%h want 04/0222", out_valid,
                     out_data[2*WIDTH +: WIDTH]);
            miscompares++;
        end
        out_ready = 8'hFF;
        #1;
        tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 8'h04 || out_data[2*WIDTH +: WIDTH] !== 16'h7777 ||
            rr_ptr !== 3'd3) begin
            $display("FAIL sw_load: got %h/%h/%0d want 04/7777/3", out_valid,
                     out_data[2*WIDTH +: WIDTH], rr_ptr);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid();
        mode = 2'b00; out_ready = '0; in_valid = 1'b1;
        sel = 3'd0; in_data = 16'h0A00; tick();
        sel = 3'd4; in_data = 16'h0A04; tick();
        sel = 3'd7; in_data = 16'h0A07; tick();
        in_valid = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 8'h95 || rr_ptr !== 3'd3) begin
            $display("FAIL mid_setup: got %h/%0d want 95/3", out_valid, rr_ptr);
            miscompares++;
        end
        #1;
        reset = 1'b1;
        #1;
        vectors++;
        if (out_valid !== 8'h00 || out_data !== '0 || rr_ptr !== 3'd0) begin
            $display("FAIL mid_async_reset: got %h/%h/%0d want 00/0/0", out_valid,
                     out_data, rr_ptr);
            miscompares++;
        end
        reset = 1'b0;
        tick();
        vectors++;
        if (out_valid !== 8'h00 || in_ready !== 1'b1) begin
            $display("FAIL mid_after: got %h/%b want 00/1", out_valid, in_ready);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_explicit();
        test_backpressure();
        test_round_robin();
        test_broadcast();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/student_dmux_stream.md
Name: student_dmux_stream

Overview:
Registered, parametrised N-way demultiplexer for word streams. It is the clocked successor of student_dmux8way: it routes an input word to one of 2^SEL_BITS output channels, with a valid/ready handshake on every side. Each channel has its own one-entry holding register. The target channel comes from one of three modes: explicit select, round-robin, or broadcast. It sits between a single producer and a bank of independent consumers.

Parameters:
WIDTH, 16, data word width in bits (>=1)
SEL_BITS, 3, select width; NUM_OUT = 2^SEL_BITS channels (SEL_BITS >= 1)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
in_data  input  WIDTH  input word
in_valid  input  1  producer offers in_data
in_ready  output  1  block accepts in_data this cycle (combinational)
sel  input  SEL_BITS  target channel in explicit mode
mode  input  2  00 explicit, 01 round-robin, 10 broadcast, 11 treated as 00
out_data  output  NUM_OUT*WIDTH  channel k data at bits [k*WIDTH +: WIDTH]
out_valid  output  NUM_OUT  channel k holds a word
out_ready  input  NUM_OUT  consumer k takes its word this cycle
rr_ptr  output  SEL_BITS  next round-robin target

Behaviour:
- Reset (async, immediate): all out_valid=0, all out_data=0, rr_ptr=0. Held words are discarded, including on reset mid-stream. in_ready follows its combinational rule from the reset state.
- Channel k is "free" when !out_valid[k] || out_ready[k], i.e. empty or draining this cycle.
- Target set T:
  - Explicit: {sel}.
  - Round-robin: {rr_ptr}; sel is ignored.
  - Broadcast: all channels; sel is ignored.
- in_ready = 1 iff every channel in T is free. It is combinational from out_ready, out_valid, mode, sel and rr_ptr. It does not depend on in_valid.
- Accept = in_valid && in_ready. On the next rising edge, every k in T gets out_data[k]=in_data and out_valid[k]=1. Latency is 1 cycle from accept to out_valid.
- A channel not loaded this edge with out_valid && out_ready clears out_valid. out_data holds its last value; it is not zeroed.
- Load and drain on the same channel in the same cycle: the old word is consumed and the new word is loaded, so out_valid stays 1. Full throughput is 1 word/cycle per channel.
- No accept: no channel is loaded, and out_data/out_valid change only by draining.
- Broadcast is all-or-nothing. It never loads a subset of channels.
- rr_ptr increments by 1 mod NUM_OUT only on an accept in round-robin mode, wrapping from NUM_OUT-1 to 0. It is unchanged in other modes and is retained across mode changes.
- mode and sel are sampled every cycle with no internal latching. Changing them while in_valid=1 and in_ready=0 is legal; the new value applies immediately.
- Held words are never overwritten before the consumer takes them, and never lost or duplicated except by reset.
- Channels are independent. A stalled channel blocks only inputs targeting it, not draining of the other channels.
- Implementation: registers for out_data/out_valid/rr_ptr only, with no FIFO beyond one entry per channel. Target decode uses the team's student_dmux family or equivalent logic, not a built-in shift-decoder primitive.

Test Plan:
1. Reset/explicit routing: reset=1 then 0; mode=00, sel=5, in_data=16'hA5A5, in_valid=1 for one cycle, out_ready=0 -> next cycle out_valid=8'b0010_0000, out_data[5]=A5A5, all other channels 0, in_ready for sel=5 drops to 0.
2. Backpressure/stall: channel 5 full, out_ready[5]=0, in_valid=1 sel=5 in_data=1234 -> in_ready=0 and channel 5 keeps A5A5. Raise out_ready[5] -> same cycle in_ready=1; next edge out_data[5]=1234, out_valid[5] stays 1.
3. Round-robin wrap: mode=01, all out_ready=1, 10 consecutive accepts of data 0..9 -> words land on channels 0..7,0,1 one cycle after each accept; rr_ptr ends at 2; sel toggling is ignored.
4. Broadcast all-or-nothing: mode=10, channel 3 full with out_ready[3]=0, in_data=BEEF -> in_ready=0 and no channel loads. Release out_ready[3] -> next edge out_valid=8'hFF, all out_data=BEEF.
5. Independence/mode switch: channel 2 stalled full; mode=00, sel=6, three words streamed -> all accepted back-to-back on channel 6. Switch to mode=01 with rr_ptr=2 -> in_ready=0 until channel 2 drains; rr_ptr unchanged by the mode-00 traffic.
6. Reset mid-operation: channels 0, 4 and 7 holding words, rr_ptr=3; assert reset between clock edges -> out_valid=0, out_data=0 and rr_ptr=0 immediately, without waiting for a clock edge.
